aes_core_arbiter: RTL and testbench
===================================

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 req0_valid / req0_ready  in / out  1 / 1  requester 0 job handshake.
REQ-004 req0_data  in  128  plaintext (encrypt) or ciphertext (decrypt) block.
REQ-005 req0_mode  in  1  0 = cipher, 1 = inverse cipher.
REQ-006 req0_klen  in  2  key length: 00 = 128, 01 = 192, 10 = 256, 11 = illegal.
REQ-007 req1_valid, req1_ready, req1_data, req1_mode, req1_klen SHALL match the req0_* ports in direction, width and meaning, for requester 1.
REQ-008 core_start  out  1  one-cycle pulse that launches the shared AES core.
REQ-009 core_mode, core_klen, core_data  out  1, 2, 128  registered copy of the granted job.
REQ-010 core_round  out  4  current round index, 0..Nr.
REQ-011 core_result  in  128  core output, valid in the cycle after round Nr.
REQ-012 rsp_valid / rsp_ready  out / in  1 / 1  result handshake.
REQ-013 rsp_data, rsp_id, rsp_err  out  128, 1, 1  result block, requester index, illegal-klen flag.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, ROUND, CAPTURE and RESP.
REQ-016 Jobs SHALL be accepted only in IDLE; reqN_ready is high only for the granted requester and only in IDLE; acceptance occurs on valid&ready.
REQ-017 Arbitration SHALL be two-way round-robin: with both valid, the requester not granted last wins; with one valid, that requester wins; after reset req0 has priority.
REQ-018 On acceptance in cycle T, core_mode, core_klen, core_data and rsp_id SHALL latch the job; the next state SHALL be LOAD (legal klen) or RESP (klen 11).
REQ-019 LOAD (cycle T+1): core_start = 1 and core_round = 0 for exactly this cycle.
REQ-020 ROUND: core_round SHALL increment each cycle, 1..Nr, with Nr = 10/12/14 for klen 00/01/10; after core_round = Nr the next state is CAPTURE.
REQ-021 CAPTURE: rsp_data <= core_result; the next state is RESP; rsp_valid SHALL first be high in cycle T+Nr+3.
REQ-022 RESP: rsp_valid = 1, and rsp_data, rsp_id and rsp_err are held stable until rsp_valid&rsp_ready, then the next state is IDLE.
REQ-023 klen 11 SHALL not pulse core_start; RESP is reached at T+1 with rsp_err = 1 and rsp_data = 0.
REQ-024 rsp_ready may be high when rsp_valid rises; the handshake completes that cycle, and the next acceptance is possible no earlier than the following IDLE cycle.
REQ-025 A requester that drops valid before being granted SHALL lose no state; arbitration is re-evaluated every IDLE cycle.
REQ-026 Input changes on the request ports after acceptance SHALL not affect the job in flight.

Reset
REQ-027 When rst_n = 0 at a clock edge, the next state SHALL be: state = IDLE, rr pointer = req1-last (so req0 wins next), core_start = 0, core_round = 0, core_mode = 0, core_klen = 0, core_data = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0, busy = 0, reqN_ready = 0.
REQ-028 Reset during LOAD, ROUND, CAPTURE or RESP SHALL abandon the job with no response emitted.

Structure
REQ-029 Package aes_ctrl_pkg SHALL hold the klen encodings, the NR_128/NR_192/NR_256 constants, the mode encoding and the FSM state typedef.
REQ-030 Sub-module rr_arbiter2 SHALL implement the two-way round-robin grant and its pointer; all other logic stays in aes_core_arbiter.

Verification (shared AES core attached, key 000102..1f truncated per klen)
REQ-031 req0 cipher, klen 00, data 00112233445566778899aabbccddeeff accepted at T -> rsp_valid at T+13, rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id 0, rsp_err 0.
REQ-032 req1 inverse cipher, klen 10, data 8ea2b7ca516745bfeafc49904b496089 -> rsp_valid at T+17, rsp_data 00112233445566778899aabbccddeeff, rsp_id 1.
REQ-033 Both requesters valid continuously, rsp_ready = 1 -> grants alternate 0,1,0,1 across four jobs, with exactly one core_start per job.
REQ-034 req0 klen 11 -> no core_start, rsp_valid at T+1, rsp_err 1, rsp_data 0.
REQ-035 rsp_ready held 0 for 20 cycles -> rsp_* stable, no new acceptance, busy = 1 throughout.
REQ-036 rst_n = 0 at ROUND core_round = 5 -> next cycle IDLE, all outputs at reset values; the next job completes normally.

Source files
------------

// File: rtl/aes_core_arbiter_pkg.sv
// Shared control definitions for the two-requester AES core front end:
// key-length and mode encodings, round counts and FSM state codes.
package aes_ctrl_pkg;

    localparam logic [1:0] KLEN_128 = 2'b00;
    localparam logic [1:0] KLEN_192 = 2'b01;
    localparam logic [1:0] KLEN_256 = 2'b10;
    localparam logic [1:0] KLEN_ILL = 2'b11;

    localparam logic MODE_CIPHER = 1'b0;
    localparam logic MODE_INV    = 1'b1;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef logic [2:0] aes_state_t;

    localparam aes_state_t ST_IDLE    = 3'd0;
    localparam aes_state_t ST_LOAD    = 3'd1;
    localparam aes_state_t ST_ROUND   = 3'd2;
    localparam aes_state_t ST_CAPTURE = 3'd3;
    localparam aes_state_t ST_RESP    = 3'd4;

    // Illegal key length never reaches the round counter, so its value is don't-care.
    function automatic logic [3:0] nr_of_klen(input logic [1:0] klen);
        logic [3:0] nr;
        case (klen)
            KLEN_128: nr = NR_128;
            KLEN_192: nr = NR_192;
            KLEN_256: nr = NR_256;
            default:  nr = NR_128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Bus bundle between the two requesters, the shared AES core and the
// response consumer; slave is the arbiter view, master the environment view.
interface aes_core_arbiter_if;

    logic         req0_valid;
    logic         req0_ready;
    logic [127:0] req0_data;
    logic         req0_mode;
    logic [1:0]   req0_klen;

    logic         req1_valid;
    logic         req1_ready;
    logic [127:0] req1_data;
    logic         req1_mode;
    logic [1:0]   req1_klen;

    logic         core_start;
    logic         core_mode;
    logic [1:0]   core_klen;
    logic [127:0] core_data;
    logic [3:0]   core_round;
    logic [127:0] core_result;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         rsp_id;
    logic         rsp_err;

    logic         busy;

    modport slave (
        input  req0_valid, req0_data, req0_mode, req0_klen,
        output req0_ready,
        input  req1_valid, req1_data, req1_mode, req1_klen,
        output req1_ready,
        output core_start, core_mode, core_klen, core_data, core_round,
        input  core_result,
        output rsp_valid, rsp_data, rsp_id, rsp_err,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_data, req0_mode, req0_klen,
        input  req0_ready,
        output req1_valid, req1_data, req1_mode, req1_klen,
        input  req1_ready,
        input  core_start, core_mode, core_klen, core_data, core_round,
        output core_result,
        input  rsp_valid, rsp_data, rsp_id, rsp_err,
        output rsp_ready,
        input  busy
    );

endinterface

// File: rtl/aes_core_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with a one-bit "last granted" pointer.
// After reset the pointer says req1 went last, so req0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_r;
    logic [1:0] grant_s;

    // Grant selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
    end

    // Pointer update only when a grant is actually consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (advance) begin
            last_r <= grant_s[1];
        end else begin
            last_r <= last_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/aes_core_arbiter.sv
// Front end for a shared iterative AES core: arbitrates two requesters,
// sequences the core rounds and returns the result over a valid/ready channel.
module aes_core_arbiter
    import aes_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    aes_core_arbiter_if.slave bus
);

    aes_state_t   state_r;
    logic         core_start_r;
    logic [3:0]   core_round_r;
    logic         core_mode_r;
    logic [1:0]   core_klen_r;
    logic [127:0] core_data_r;
    logic         rsp_valid_r;
    logic [127:0] rsp_data_r;
    logic         rsp_id_r;
    logic         rsp_err_r;
    logic         busy_r;

    logic [1:0]   req_valid_s;
    logic [1:0]   grant_s;
    logic         idle_s;
    logic         ready0_s;
    logic         ready1_s;
    logic         accept_s;
    logic         sel_s;
    logic [127:0] sel_data_s;
    logic         sel_mode_s;
    logic [1:0]   sel_klen_s;
    logic [3:0]   nr_s;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid_s),
        .advance (accept_s),
        .grant   (grant_s)
    );

    // Ready follows the live grant so a requester that drops valid in IDLE is simply skipped.
    always_comb begin
        req_valid_s = {bus.req1_valid, bus.req0_valid};
        idle_s      = (state_r == ST_IDLE);
        ready0_s    = rst_n & idle_s & grant_s[0];
        ready1_s    = rst_n & idle_s & grant_s[1];
        accept_s    = (ready0_s & bus.req0_valid) | (ready1_s & bus.req1_valid);
        sel_s       = grant_s[1];
        nr_s        = nr_of_klen(core_klen_r);
        if (sel_s) begin
            sel_data_s = bus.req1_data;
            sel_mode_s = bus.req1_mode;
            sel_klen_s = bus.req1_klen;
        end else begin
            sel_data_s = bus.req0_data;
            sel_mode_s = bus.req0_mode;
            sel_klen_s = bus.req0_klen;
        end
    end

    // Job sequencer: accept, launch, count rounds, capture, hand the result back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            core_start_r <= 1'b0;
            core_round_r <= 4'd0;
            core_mode_r  <= MODE_CIPHER;
            core_klen_r  <= KLEN_128;
            core_data_r  <= 128'd0;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= 128'd0;
            rsp_id_r     <= 1'b0;
            rsp_err_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    core_round_r <= 4'd0;
                    if (accept_s) begin
                        core_mode_r <= sel_mode_s;
                        core_klen_r <= sel_klen_s;
                        core_data_r <= sel_data_s;
                        rsp_id_r    <= sel_s;
                        busy_r      <= 1'b1;
                        // Illegal key length bypasses the core and reports straight away.
                        if (sel_klen_s == KLEN_ILL) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_data_r  <= 128'd0;
                        end else begin
                            state_r      <= ST_LOAD;
                            core_start_r <= 1'b1;
                            rsp_err_r    <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    core_start_r <= 1'b0;
                    core_round_r <= 4'd1;
                    state_r      <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (core_round_r == nr_s) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        core_round_r <= core_round_r + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    rsp_data_r  <= bus.core_result;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    core_start_r <= 1'b0;
                    rsp_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.core_start = core_start_r;
    assign bus.core_round = core_round_r;
    assign bus.core_mode  = core_mode_r;
    assign bus.core_klen  = core_klen_r;
    assign bus.core_data  = core_data_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter with a stand-in core whose result
// is a keyed mix of the job, presented only in the cycle after the last round.
module tb_aes_core_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_core_arbiter_if bus ();

    aes_core_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors    = 0;
    int checks    = 0;
    int start_cnt = 0;
    int last_g    = 1;

    logic         cs_act  = 1'b0;
    int           cs_cnt  = 0;
    logic [127:0] cs_data = 128'd0;
    logic         cs_mode = 1'b0;
    logic [1:0]   cs_klen = 2'd0;

    logic [127:0] p_data [2];
    logic         p_mode [2];
    logic [1:0]   p_klen [2];
    bit           p_v    [2];

    function automatic int nr_of(input logic [1:0] k);
        return 10 + 2 * int'(k);
    endfunction

    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic m, input logic [1:0] k);
        logic [127:0] key;
        key = {16{1'b1, m, k, 4'h5}};
        return {d[119:0], d[127:120]} ^ key;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int pick(input bit v0, input bit v1, input int last);
        if (v0 && v1) return (last == 0) ? 1 : 0;
        if (v0) return 0;
        return 1;
    endfunction

    // Stand-in core: counts cycles from core_start and answers one cycle after round Nr.
    always @(posedge clk) begin
        if (!rst_n) begin
            cs_act <= 1'b0;
        end else if (bus.core_start) begin
            cs_act    <= 1'b1;
            cs_cnt    <= 0;
            cs_data   <= bus.core_data;
            cs_mode   <= bus.core_mode;
            cs_klen   <= bus.core_klen;
            start_cnt <= start_cnt + 1;
        end else if (cs_act) begin
            cs_cnt <= cs_cnt + 1;
            if (cs_cnt > 16) cs_act <= 1'b0;
        end
    end

    always_comb begin
        if (cs_act && cs_cnt == nr_of(cs_klen)) bus.core_result = core_fn(cs_data, cs_mode, cs_klen);
        else bus.core_result = 128'hdead_beef_0bad_f00d_dead_beef_0bad_f00d;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        bus.req0_valid = p_v[0];
        bus.req0_data  = p_data[0];
        bus.req0_mode  = p_mode[0];
        bus.req0_klen  = p_klen[0];
        bus.req1_valid = p_v[1];
        bus.req1_data  = p_data[1];
        bus.req1_mode  = p_mode[1];
        bus.req1_klen  = p_klen[1];
    endtask

    task automatic set_job(input int idx, input logic [127:0] d, input logic m, input logic [1:0] k);
        p_data[idx] = d;
        p_mode[idx] = m;
        p_klen[idx] = k;
        p_v[idx]    = 1'b1;
    endtask

    task automatic rand_job(input int idx, input bit v);
        p_data[idx] = rand128();
        p_mode[idx] = 1'($urandom_range(0, 1));
        p_klen[idx] = 2'($urandom_range(0, 3));
        p_v[idx]    = v;
    endtask

    task automatic check_reset();
        chk("rst_busy",   bus.busy,       0);
        chk("rst_rvalid", bus.rsp_valid,  0);
        chk("rst_start",  bus.core_start, 0);
        chk("rst_round",  bus.core_round, 0);
        chk("rst_mode",   bus.core_mode,  0);
        chk("rst_klen",   bus.core_klen,  0);
        chk("rst_cdata",  bus.core_data,  0);
        chk("rst_rdata",  bus.rsp_data,   0);
        chk("rst_id",     bus.rsp_id,     0);
        chk("rst_err",    bus.rsp_err,    0);
        chk("rst_rdy0",   bus.req0_ready, 0);
        chk("rst_rdy1",   bus.req1_ready, 0);
    endtask

    // One complete job: predicted winner, launch, latency, result, optional back-pressure.
    task automatic serve(input int hold, input bit keep_both);
        int w, lat, lat_e, s0;
        bit got, e_err;
        logic [127:0] e_data, j_data;
        logic j_mode;
        logic [1:0] j_klen;
        got = 1'b0;
        bus.rsp_ready = (hold == 0);
        drive_reqs();
        #1;
        for (int i = 0; i < 60 && !got; i++) begin
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) got = 1'b1;
            else step();
        end
        if (!got) begin
            chk("accept_wait", 0, 1);
            return;
        end
        w = pick(p_v[0], p_v[1], last_g);
        chk("grant0", bus.req0_ready, (w == 0));
        chk("grant1", bus.req1_ready, (w == 1));
        j_data = p_data[w];
        j_mode = p_mode[w];
        j_klen = p_klen[w];
        e_err  = (j_klen == 2'b11);
        e_data = e_err ? 128'd0 : core_fn(j_data, j_mode, j_klen);
        lat_e  = e_err ? 1 : nr_of(j_klen) + 3;
        last_g = w;
        s0     = start_cnt;
        step();
        rand_job(w, keep_both);
        drive_reqs();
        #1;
        chk("load_start", bus.core_start, !e_err);
        chk("load_busy",  bus.busy, 1);
        if (!e_err) begin
            chk("load_round", bus.core_round, 0);
            chk("load_data",  bus.core_data, j_data);
            chk("load_mode",  bus.core_mode, j_mode);
            chk("load_klen",  bus.core_klen, j_klen);
        end
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("latency",  lat, lat_e);
        chk("rsp_id",   bus.rsp_id, w);
        chk("rsp_err",  bus.rsp_err, e_err);
        chk("rsp_data", bus.rsp_data, e_data);
        chk("starts",   start_cnt - s0, e_err ? 0 : 1);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_data",  bus.rsp_data, e_data);
            chk("hold_id",    bus.rsp_id, w);
            chk("hold_err",   bus.rsp_err, e_err);
            chk("hold_busy",  bus.busy, 1);
            chk("hold_rdy0",  bus.req0_ready, 0);
            chk("hold_rdy1",  bus.req1_ready, 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("rsp_drop",  bus.rsp_valid, 0);
        chk("idle_busy", bus.busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            p_data[i] = 128'd0;
            p_mode[i] = 1'b0;
            p_klen[i] = 2'd0;
            p_v[i]    = 1'b0;
        end
        drive_reqs();
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        check_reset();
        rst_n = 1'b1;
        step();

        // Directed vectors: cipher/128 from req0, inverse/256 from req1, illegal key length.
        set_job(0, 128'h00112233445566778899aabbccddeeff, 1'b0, 2'b00);
        serve(0, 1'b0);
        set_job(1, 128'h8ea2b7ca516745bfeafc49904b496089, 1'b1, 2'b10);
        serve(0, 1'b0);
        set_job(0, rand128(), 1'b0, 2'b11);
        serve(0, 1'b0);

        // Reset in the middle of round 5 abandons the job.
        set_job(0, rand128(), 1'b0, 2'b00);
        drive_reqs();
        #1;
        chk("mid_rdy0", bus.req0_ready, 1);
        step();
        p_v[0] = 1'b0;
        drive_reqs();
        for (int i = 0; i < 30 && bus.core_round != 4'd5; i++) step();
        chk("mid_round5", bus.core_round, 5);
        chk("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        step();
        check_reset();
        rst_n  = 1'b1;
        last_g = 1;
        for (int i = 0; i < 15; i++) begin
            chk("mid_norsp", bus.rsp_valid, 0);
            step();
        end

        // Tie after reset goes to req0, then the pending req1.
        rand_job(0, 1'b1);
        rand_job(1, 1'b1);
        serve(0, 1'b0);
        serve(0, 1'b0);

        // Both requesters held valid: grants must alternate.
        rand_job(0, 1'b1);
        rand_job(1, 1'b1);
        repeat (4) serve(0, 1'b1);
        p_v[0] = 1'b0;
        p_v[1] = 1'b0;
        drive_reqs();
        step();

        // Twenty cycles of back-pressure while the other requester waits.
        set_job(0, rand128(), 1'b1, 2'b01);
        rand_job(1, 1'b1);
        serve(20, 1'b0);
        serve(0, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 14; n++) begin
            if (!p_v[0] && $urandom_range(0, 1) == 1) rand_job(0, 1'b1);
            if (!p_v[1] && $urandom_range(0, 1) == 1) rand_job(1, 1'b1);
            if (!p_v[0] && !p_v[1]) rand_job(int'($urandom_range(0, 1)), 1'b1);
            serve(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0);
        end
        p_v[0] = 1'b0;
        p_v[1] = 1'b0;
        drive_reqs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
